// File: rtl/sparse_mac_lanes_pkg.sv
// Shared state encoding and elaboration helpers for the zero-skipping MAC lanes.
package sparse_mac_lanes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [1:0] DRAIN_CYCLES = 2'd2;

  function automatic int clog2(input int value);
    int r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int default_acc_width(input int channel_depth, input int data_width);
    return 2 * data_width + clog2(channel_depth);
  endfunction

endpackage

// File: rtl/sparse_mac_lanes_if.sv
// PE controller <-> MAC lane bundle: start handshake, compressed operands, result and status.
interface sparse_mac_lanes_if
  import sparse_mac_lanes_pkg::*;
#(
  parameter int CHANNEL_DEPTH = 32,
  parameter int DATA_WIDTH    = 8,
  parameter int ACC_WIDTH     = default_acc_width(CHANNEL_DEPTH, DATA_WIDTH)
);

  logic                                PECMAC_Sta;
  logic                                MACPEC_Rdy;
  logic [CHANNEL_DEPTH-1:0]            PECMAC_FlgAct;
  logic [DATA_WIDTH*CHANNEL_DEPTH-1:0] PECMAC_Act;
  logic [CHANNEL_DEPTH-1:0]            PECMAC_FlgWei;
  logic [DATA_WIDTH*CHANNEL_DEPTH-1:0] PECMAC_Wei;
  logic [ACC_WIDTH-1:0]                MACMAC_Psum;
  logic [ACC_WIDTH-1:0]                MACCNV_Mac;
  logic                                MACPEC_Fnh;
  logic                                MACPEC_Ovf;
  logic [clog2(CHANNEL_DEPTH):0]       MACPEC_Cnt;

  modport master (
    output PECMAC_Sta, PECMAC_FlgAct, PECMAC_Act, PECMAC_FlgWei, PECMAC_Wei, MACMAC_Psum,
    input  MACPEC_Rdy, MACCNV_Mac, MACPEC_Fnh, MACPEC_Ovf, MACPEC_Cnt
  );

  modport slave (
    input  PECMAC_Sta, PECMAC_FlgAct, PECMAC_Act, PECMAC_FlgWei, PECMAC_Wei, MACMAC_Psum,
    output MACPEC_Rdy, MACCNV_Mac, MACPEC_Fnh, MACPEC_Ovf, MACPEC_Cnt
  );

endinterface

// File: rtl/sparse_mac_lanes_ffs_sel.sv
// Picks the lowest LANES set bits of a vector: one one-hot mask per lane plus lane-valid flags.
module sparse_ffs_sel #(
  parameter int WIDTH = 32,
  parameter int LANES = 1
) (
  input  logic [WIDTH-1:0]            vec,
  output logic [LANES-1:0][WIDTH-1:0] mask,
  output logic [LANES-1:0]            valid
);

  always_comb begin
    logic [WIDTH-1:0] rem;
    rem   = vec;
    mask  = '0;
    valid = '0;
    for (int l = 0; l < LANES; l++) begin
      mask[l]  = rem & (~rem + WIDTH'(1));
      valid[l] = |rem;
      rem      = rem & ~mask[l];
    end
  end

endmodule

// File: rtl/sparse_mac_lanes.sv
// Zero-skipping multiply-accumulate: issues up to LANES matched act/wei pairs per SCAN cycle
// into a registered product stage, then folds them into the accumulator with wrap or clamp.
//
// state    | meaning
// ST_IDLE  | ready; waiting for an accepted start
// ST_SCAN  | issuing matched pairs, lowest channels first
// ST_DRAIN | product/accumulate pipeline emptying; down-counter to completion
module sparse_mac_lanes
  import sparse_mac_lanes_pkg::*;
#(
  parameter int CHANNEL_DEPTH = 32,
  parameter int DATA_WIDTH    = 8,
  parameter int LANES         = 1,
  parameter int SIGNED        = 0,
  parameter int ACC_WIDTH     = default_acc_width(CHANNEL_DEPTH, DATA_WIDTH),
  parameter int SATURATE      = 0
) (
  input logic               clk,
  input logic               rst,
  sparse_mac_lanes_if.slave bus
);

  localparam int IW = clog2(CHANNEL_DEPTH);
  localparam int CW = IW + 1;
  localparam int PW = 2 * DATA_WIDTH + 2;
  localparam int EW = (ACC_WIDTH + 3 > PW + 1) ? ACC_WIDTH + 3 : PW + 1;

  state_e state_q, state_nxt;
  logic [1:0] drain_q, drain_nxt;
  logic       fnh_nxt;
  logic       accept;

  logic [CHANNEL_DEPTH-1:0]                 flg_act_q, flg_wei_q, match_q;
  logic [CHANNEL_DEPTH-1:0][DATA_WIDTH-1:0] act_q, wei_q;
  logic [ACC_WIDTH-1:0]                     mac_q;
  logic                                     ovf_q;
  logic                                     fnh_q;
  logic [CW-1:0]                            cnt_q;

  logic [LANES-1:0][CHANNEL_DEPTH-1:0] lane_mask;
  logic [LANES-1:0]                    lane_valid;
  logic [CHANNEL_DEPTH-1:0]            sel_all;
  logic [CHANNEL_DEPTH-1:0][IW-1:0]    act_idx, wei_idx;
  logic [LANES-1:0][ACC_WIDTH-1:0]     prod_nxt, prod_q;
  logic [LANES-1:0]                    valid_q;

  logic [EW-1:0]        sum;
  logic                 ovf_now;
  logic [ACC_WIDTH-1:0] mac_upd;

  function automatic logic [EW-1:0] widen(input logic [ACC_WIDTH-1:0] v);
    return {{(EW-ACC_WIDTH){(SIGNED != 0) & v[ACC_WIDTH-1]}}, v};
  endfunction

  sparse_ffs_sel #(
    .WIDTH (CHANNEL_DEPTH),
    .LANES (LANES)
  ) u_sel (
    .vec   (match_q),
    .mask  (lane_mask),
    .valid (lane_valid)
  );

  always_comb begin
    sel_all = '0;
    for (int l = 0; l < LANES; l++) sel_all = sel_all | lane_mask[l];
  end

  // Compressed data index of channel c is the count of set flags up to and including c, minus one.
  always_comb begin
    logic [CW-1:0] run_a, run_w;
    run_a   = '0;
    run_w   = '0;
    act_idx = '0;
    wei_idx = '0;
    for (int c = 0; c < CHANNEL_DEPTH; c++) begin
      run_a      = run_a + CW'(flg_act_q[c]);
      run_w      = run_w + CW'(flg_wei_q[c]);
      act_idx[c] = IW'(run_a - CW'(1));
      wei_idx[c] = IW'(run_w - CW'(1));
    end
  end

  // Operands are widened with the sign bit chosen per SIGNED so a single multiply covers both modes.
  always_comb begin
    logic [IW-1:0] a_addr, w_addr;
    logic [PW-1:0] a_op, w_op, p;
    logic [EW-1:0] p_ext;
    prod_nxt = '0;
    a_addr   = '0;
    w_addr   = '0;
    a_op     = '0;
    w_op     = '0;
    p        = '0;
    p_ext    = '0;
    for (int l = 0; l < LANES; l++) begin
      a_addr = '0;
      w_addr = '0;
      for (int c = 0; c < CHANNEL_DEPTH; c++) begin
        if (lane_mask[l][c]) begin
          a_addr = a_addr | act_idx[c];
          w_addr = w_addr | wei_idx[c];
        end
      end
      a_op  = {{(PW-DATA_WIDTH){(SIGNED != 0) & act_q[a_addr][DATA_WIDTH-1]}}, act_q[a_addr]};
      w_op  = {{(PW-DATA_WIDTH){(SIGNED != 0) & wei_q[w_addr][DATA_WIDTH-1]}}, wei_q[w_addr]};
      p     = a_op * w_op;
      p_ext = {{(EW-PW){p[PW-1]}}, p};
      prod_nxt[l] = p_ext[ACC_WIDTH-1:0];
    end
  end

  always_comb begin
    sum = widen(mac_q);
    for (int l = 0; l < LANES; l++) begin
      if (valid_q[l]) sum = sum + widen(prod_q[l]);
    end
    if (SIGNED != 0) begin
      ovf_now = (sum[EW-1:ACC_WIDTH-1] != '0) && (sum[EW-1:ACC_WIDTH-1] != '1);
    end else begin
      ovf_now = (sum[EW-1:ACC_WIDTH] != '0);
    end
    mac_upd = sum[ACC_WIDTH-1:0];
    if (ovf_now && (SATURATE != 0)) begin
      if (SIGNED == 0)   mac_upd = '1;
      else if (sum[EW-1]) mac_upd = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else               mac_upd = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    state_nxt = state_q;
    drain_nxt = drain_q;
    fnh_nxt   = 1'b0;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.PECMAC_Sta) begin
          accept    = 1'b1;
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if ((match_q & ~sel_all) == '0) begin
          state_nxt = ST_DRAIN;
          drain_nxt = DRAIN_CYCLES;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 2'd1) begin
          state_nxt = ST_IDLE;
          fnh_nxt   = 1'b1;
        end else begin
          drain_nxt = drain_q - 2'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      fnh_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      drain_q <= drain_nxt;
      fnh_q   <= fnh_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flg_act_q <= '0;
      flg_wei_q <= '0;
      match_q   <= '0;
      act_q     <= '0;
      wei_q     <= '0;
      mac_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      prod_q    <= '0;
      valid_q   <= '0;
    end else begin
      if (accept) begin
        flg_act_q <= bus.PECMAC_FlgAct;
        flg_wei_q <= bus.PECMAC_FlgWei;
        match_q   <= bus.PECMAC_FlgAct & bus.PECMAC_FlgWei;
        act_q     <= bus.PECMAC_Act;
        wei_q     <= bus.PECMAC_Wei;
        cnt_q     <= CW'($countones(bus.PECMAC_FlgAct & bus.PECMAC_FlgWei));
      end else if (state_q == ST_SCAN) begin
        match_q <= match_q & ~sel_all;
      end

      if (accept) begin
        mac_q <= bus.MACMAC_Psum;
        ovf_q <= 1'b0;
      end else if (|valid_q) begin
        mac_q <= mac_upd;
        ovf_q <= ovf_q | ovf_now;
      end

      prod_q  <= prod_nxt;
      valid_q <= (state_q == ST_SCAN) ? lane_valid : '0;
    end
  end

  assign bus.MACPEC_Rdy = (state_q == ST_IDLE);
  assign bus.MACCNV_Mac = mac_q;
  assign bus.MACPEC_Fnh = fnh_q;
  assign bus.MACPEC_Ovf = ovf_q;
  assign bus.MACPEC_Cnt = cnt_q;

endmodule

// File: tb/tb_sparse_mac_lanes.sv
// Directed bench: six configurations share one stimulus bus; expectations are hand-computed.
module tb_sparse_mac_lanes;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sta = 1'b0;
  logic [7:0]  flg_a = '0;
  logic [7:0]  flg_w = '0;
  logic [63:0] act = '0;
  logic [63:0] wei = '0;
  logic [18:0] psum = '0;

  int passed = 0;
  int total  = 0;
  int lat[6];
  int pulses[6];
  logic rdy0, rdy1;
  logic [5:0] fnh_all;

  always #5 clk = ~clk;

  sparse_mac_lanes_if #(.CHANNEL_DEPTH(8), .DATA_WIDTH(8), .ACC_WIDTH(19)) bus_u1 ();
  sparse_mac_lanes_if #(.CHANNEL_DEPTH(8), .DATA_WIDTH(8), .ACC_WIDTH(19)) bus_s19 ();
  sparse_mac_lanes_if #(.CHANNEL_DEPTH(8), .DATA_WIDTH(8), .ACC_WIDTH(16)) bus_sat ();
  sparse_mac_lanes_if #(.CHANNEL_DEPTH(8), .DATA_WIDTH(8), .ACC_WIDTH(16)) bus_wrap ();
  sparse_mac_lanes_if #(.CHANNEL_DEPTH(8), .DATA_WIDTH(8), .ACC_WIDTH(19)) bus_l2 ();
  sparse_mac_lanes_if #(.CHANNEL_DEPTH(8), .DATA_WIDTH(8), .ACC_WIDTH(19)) bus_l4 ();

  assign bus_u1.PECMAC_Sta = sta, bus_u1.PECMAC_FlgAct = flg_a, bus_u1.PECMAC_FlgWei = flg_w,
         bus_u1.PECMAC_Act = act, bus_u1.PECMAC_Wei = wei, bus_u1.MACMAC_Psum = psum;
  assign bus_s19.PECMAC_Sta = sta, bus_s19.PECMAC_FlgAct = flg_a, bus_s19.PECMAC_FlgWei = flg_w,
         bus_s19.PECMAC_Act = act, bus_s19.PECMAC_Wei = wei, bus_s19.MACMAC_Psum = psum;
  assign bus_sat.PECMAC_Sta = sta, bus_sat.PECMAC_FlgAct = flg_a, bus_sat.PECMAC_FlgWei = flg_w,
         bus_sat.PECMAC_Act = act, bus_sat.PECMAC_Wei = wei, bus_sat.MACMAC_Psum = psum[15:0];
  assign bus_wrap.PECMAC_Sta = sta, bus_wrap.PECMAC_FlgAct = flg_a, bus_wrap.PECMAC_FlgWei = flg_w,
         bus_wrap.PECMAC_Act = act, bus_wrap.PECMAC_Wei = wei, bus_wrap.MACMAC_Psum = psum[15:0];
  assign bus_l2.PECMAC_Sta = sta, bus_l2.PECMAC_FlgAct = flg_a, bus_l2.PECMAC_FlgWei = flg_w,
         bus_l2.PECMAC_Act = act, bus_l2.PECMAC_Wei = wei, bus_l2.MACMAC_Psum = psum;
  assign bus_l4.PECMAC_Sta = sta, bus_l4.PECMAC_FlgAct = flg_a, bus_l4.PECMAC_FlgWei = flg_w,
         bus_l4.PECMAC_Act = act, bus_l4.PECMAC_Wei = wei, bus_l4.MACMAC_Psum = psum;

  assign fnh_all = {bus_l4.MACPEC_Fnh, bus_l2.MACPEC_Fnh, bus_wrap.MACPEC_Fnh,
                    bus_sat.MACPEC_Fnh, bus_s19.MACPEC_Fnh, bus_u1.MACPEC_Fnh};

  sparse_mac_lanes #(.CHANNEL_DEPTH(8), .DATA_WIDTH(8), .LANES(1), .SIGNED(0), .ACC_WIDTH(19), .SATURATE(0))
    dut_u1 (.clk(clk), .rst(rst), .bus(bus_u1));
  sparse_mac_lanes #(.CHANNEL_DEPTH(8), .DATA_WIDTH(8), .LANES(1), .SIGNED(1), .ACC_WIDTH(19), .SATURATE(0))
    dut_s19 (.clk(clk), .rst(rst), .bus(bus_s19));
  sparse_mac_lanes #(.CHANNEL_DEPTH(8), .DATA_WIDTH(8), .LANES(1), .SIGNED(1), .ACC_WIDTH(16), .SATURATE(1))
    dut_sat (.clk(clk), .rst(rst), .bus(bus_sat));
  sparse_mac_lanes #(.CHANNEL_DEPTH(8), .DATA_WIDTH(8), .LANES(1), .SIGNED(1), .ACC_WIDTH(16), .SATURATE(0))
    dut_wrap (.clk(clk), .rst(rst), .bus(bus_wrap));
  sparse_mac_lanes #(.CHANNEL_DEPTH(8), .DATA_WIDTH(8), .LANES(2), .SIGNED(0), .ACC_WIDTH(19), .SATURATE(0))
    dut_l2 (.clk(clk), .rst(rst), .bus(bus_l2));
  sparse_mac_lanes #(.CHANNEL_DEPTH(8), .DATA_WIDTH(8), .LANES(4), .SIGNED(0), .ACC_WIDTH(19), .SATURATE(0))
    dut_l4 (.clk(clk), .rst(rst), .bus(bus_l4));

  function automatic logic [63:0] pack(input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start sampled at edge T; lat[i] is the first k with Fnh high after edge T+k.
  task automatic run_op(input bit hold);
    for (int i = 0; i < 6; i++) begin
      lat[i]    = -1;
      pulses[i] = 0;
    end
    sta = 1'b1;
    @(posedge clk); #1;
    if (!hold) sta = 1'b0;
    rdy0 = bus_u1.MACPEC_Rdy;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (k == 1) rdy1 = bus_u1.MACPEC_Rdy;
      for (int i = 0; i < 6; i++) begin
        if (fnh_all[i]) begin
          pulses[i]++;
          if (lat[i] < 0) lat[i] = k;
        end
      end
      if (hold && lat[0] > 0) sta = 1'b0;
    end
  endtask

  task automatic set_basic(input logic [18:0] ps);
    flg_a = 8'b10110110;
    flg_w = 8'b01100101;
    act   = pack(8'd9, 8'd3, 8'd7, 8'd4, 8'd2, 8'd0, 8'd0, 8'd0);
    wei   = pack(8'd1, 8'd5, 8'd6, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0);
    psum  = ps;
  endtask

  initial begin
    int fnh_seen;
    int k1, k2;

    idle(2);
    chk("reset_rdy", bus_u1.MACPEC_Rdy, 1);
    chk("reset_mac", bus_u1.MACCNV_Mac, 0);
    chk("reset_fnh", bus_u1.MACPEC_Fnh, 0);
    chk("reset_ovf", bus_u1.MACPEC_Ovf, 0);
    chk("reset_cnt", bus_u1.MACPEC_Cnt, 0);
    rst = 1'b0;
    idle(2);

    // Matches on ch2 (3*5) and ch5 (4*6) on top of 100
    set_basic(19'd100);
    run_op(1'b0);
    chk("basic_rdy_fall", rdy0, 0);
    chk("basic_cnt", bus_u1.MACPEC_Cnt, 2);
    chk("basic_mac", bus_u1.MACCNV_Mac, 139);
    chk("basic_lat", lat[0], 4);
    chk("basic_pulses", pulses[0], 1);
    chk("basic_ovf", bus_u1.MACPEC_Ovf, 0);
    chk("basic_l2_lat", lat[4], 3);
    chk("basic_l2_mac", bus_l2.MACCNV_Mac, 139);
    chk("basic_s19_mac", bus_s19.MACCNV_Mac, 139);
    idle(2);

    flg_a = 8'h0F;
    flg_w = 8'hF0;
    psum  = 19'd55;
    run_op(1'b0);
    chk("nomatch_mac", bus_u1.MACCNV_Mac, 55);
    chk("nomatch_cnt", bus_u1.MACPEC_Cnt, 0);
    chk("nomatch_lat", lat[0], 3);
    chk("nomatch_ovf", bus_u1.MACPEC_Ovf, 0);
    chk("nomatch_l4_lat", lat[5], 3);
    idle(2);

    // Eight (-128)*(-128) products: 131072 fits 19 bits signed, overflows 16 bits
    flg_a = 8'hFF;
    flg_w = 8'hFF;
    act   = {8{8'h80}};
    wei   = {8{8'h80}};
    psum  = 19'd0;
    run_op(1'b0);
    chk("signed_s19_mac", bus_s19.MACCNV_Mac, 131072);
    chk("signed_s19_ovf", bus_s19.MACPEC_Ovf, 0);
    chk("signed_s19_lat", lat[1], 10);
    chk("signed_sat_mac", bus_sat.MACCNV_Mac, 32767);
    chk("signed_sat_ovf", bus_sat.MACPEC_Ovf, 1);
    chk("signed_wrap_mac", bus_wrap.MACCNV_Mac, 0);
    chk("signed_wrap_ovf", bus_wrap.MACPEC_Ovf, 1);
    chk("unsigned_128sq_mac", bus_u1.MACCNV_Mac, 131072);
    chk("full_cnt", bus_u1.MACPEC_Cnt, 8);
    idle(2);

    act  = pack(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    wei  = pack(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    psum = 19'd0;
    run_op(1'b0);
    chk("lanes2_mac", bus_l2.MACCNV_Mac, 204);
    chk("lanes2_lat", lat[4], 6);
    chk("lanes4_mac", bus_l4.MACCNV_Mac, 204);
    chk("lanes4_lat", lat[5], 4);
    chk("lanes1_mac", bus_u1.MACCNV_Mac, 204);
    idle(2);

    set_basic(19'd100);
    run_op(1'b1);
    chk("hold_rdy_t0", rdy0, 0);
    chk("hold_rdy_scan", rdy1, 0);
    chk("hold_lat", lat[0], 4);
    chk("hold_pulses", pulses[0], 1);
    chk("hold_mac", bus_u1.MACCNV_Mac, 139);
    idle(4);

    set_basic(19'd100);
    sta = 1'b1;
    @(posedge clk); #1;
    sta = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_mac", bus_u1.MACCNV_Mac, 0);
    chk("rst_mid_rdy", bus_u1.MACPEC_Rdy, 1);
    chk("rst_mid_fnh", bus_u1.MACPEC_Fnh, 0);
    chk("rst_mid_cnt", bus_u1.MACPEC_Cnt, 0);
    rst = 1'b0;
    fnh_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus_u1.MACPEC_Fnh) fnh_seen++;
    end
    chk("rst_mid_no_fnh", fnh_seen, 0);
    idle(2);

    // Second start presented in the Fnh cycle, sampled at T+S+3
    set_basic(19'd100);
    sta = 1'b1;
    @(posedge clk); #1;
    sta = 1'b0;
    k1 = -1;
    for (int k = 1; k <= 14 && k1 < 0; k++) begin
      @(posedge clk); #1;
      if (bus_u1.MACPEC_Fnh) k1 = k;
    end
    chk("b2b_first_lat", k1, 4);
    chk("b2b_fnh_rdy", bus_u1.MACPEC_Rdy, 1);
    psum = 19'd7;
    sta  = 1'b1;
    @(posedge clk); #1;
    sta = 1'b0;
    chk("b2b_accept_rdy", bus_u1.MACPEC_Rdy, 0);
    chk("b2b_psum_load", bus_u1.MACCNV_Mac, 7);
    k2 = -1;
    for (int k = 1; k <= 14 && k2 < 0; k++) begin
      @(posedge clk); #1;
      if (bus_u1.MACPEC_Fnh) k2 = k;
    end
    chk("b2b_second_lat", k2, 4);
    chk("b2b_second_mac", bus_u1.MACCNV_Mac, 46);
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
